// File: rtl/clock_mode_pkg.sv
// Shared types and constants for the clock-mode sequencer and its phase model.
package clock_mode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BND = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_DONE     = 2'd3
  } seq_state_e;

  localparam int unsigned DIV2_PERIOD = 2;
  localparam int unsigned DIV4_PERIOD = 4;

  // Last phase value of the current divide period (the wrap/boundary phase).
  function automatic logic [1:0] last_phase(input logic div4not2);
    return div4not2 ? 2'(DIV4_PERIOD - 1) : 2'(DIV2_PERIOD - 1);
  endfunction

endpackage

// File: rtl/clock_phase_model_m.sv
// Tracks the divider's internal phase and decodes predictive rise/fall strobes.
module clock_phase_model_m
  import clock_mode_pkg::*;
(
  input  logic       gated_clk_w,
  input  logic       resetb,
  input  logic       div4not2,
  input  logic       sync_zero,
  output logic [1:0] phase,
  output logic       wrap,
  output logic       rise_stb,
  output logic       fall_stb
);

  logic [1:0] last;

  always_comb begin
    last     = last_phase(div4not2);
    wrap     = (phase == last);
    // The divided clock rises on the edge that closes the period.
    rise_stb = wrap;
    fall_stb = div4not2 ? (phase == 2'd1) : (phase == 2'd0);
  end

  always_ff @(posedge gated_clk_w or negedge resetb) begin
    if (!resetb) begin
      phase <= '0;
    end else if (sync_zero || wrap) begin
      phase <= '0;
    end else begin
      phase <= phase + 2'd1;
    end
  end

endmodule

// File: rtl/clock_mode_sequencer_m.sv
// Sequences div2/div4 mode changes onto phase boundaries with a valid/ready handshake.
// Optional change counter enabled by defining CLKSEQ_CHANGE_COUNT_EN.
module clock_mode_sequencer_m
  import clock_mode_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic        RESET_DIV4    = 1'b1
) (
  input  logic       gated_clk_w,
  input  logic       resetb,
  input  logic       req_valid,
  input  logic       req_div4not2,
  output logic       req_ready,
  output logic       done_stb,
  output logic       div4not2,
  output logic [1:0] phase,
  output logic       rise_stb,
  output logic       fall_stb,
  output logic       busy
`ifdef CLKSEQ_CHANGE_COUNT_EN
  ,
  output logic [7:0] change_count
`endif
);

  seq_state_e state_q, state_d;
  logic       req_q;
  logic [3:0] settle_q;
  logic       wrap;
  logic       load_req;
  logic       do_switch;

  clock_phase_model_m u_phase (
    .gated_clk_w (gated_clk_w),
    .resetb      (resetb),
    .div4not2    (div4not2),
    .sync_zero   (do_switch),
    .phase       (phase),
    .wrap        (wrap),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    load_req  = 1'b0;
    do_switch = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          load_req = 1'b1;
          state_d  = (req_div4not2 == div4not2) ? ST_DONE : ST_WAIT_BND;
        end
      end
      ST_WAIT_BND: begin
        // The accept edge leaves IDLE, so it can never double as the switch edge.
        if (wrap) begin
          do_switch = 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == 4'(SETTLE_CYCLES - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    done_stb  = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge gated_clk_w or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge gated_clk_w or negedge resetb) begin
    if (!resetb) begin
      req_q    <= RESET_DIV4;
      div4not2 <= RESET_DIV4;
      settle_q <= '0;
    end else begin
      if (load_req) req_q <= req_div4not2;
      if (do_switch) begin
        div4not2 <= req_q;
        settle_q <= '0;
      end else if (state_q == ST_SETTLE) begin
        settle_q <= settle_q + 4'd1;
      end
    end
  end

`ifdef CLKSEQ_CHANGE_COUNT_EN
  always_ff @(posedge gated_clk_w or negedge resetb) begin
    if (!resetb) begin
      change_count <= '0;
    end else if (do_switch) begin
      change_count <= change_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_mode_sequencer_m.sv
// Directed self-checking bench for clock_mode_sequencer_m (SETTLE_CYCLES=2, RESET_DIV4=1).
module tb_clock_mode_sequencer_m;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_div4not2 = 1'b0;
  logic       req_ready, done_stb, div4not2, rise_stb, fall_stb, busy;
  logic [1:0] phase;
`ifdef CLKSEQ_CHANGE_COUNT_EN
  logic [7:0] change_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  clock_mode_sequencer_m #(.SETTLE_CYCLES(2), .RESET_DIV4(1'b1)) dut (
    .gated_clk_w  (clk),
    .resetb       (resetb),
    .req_valid    (req_valid),
    .req_div4not2 (req_div4not2),
    .req_ready    (req_ready),
    .done_stb     (done_stb),
    .div4not2     (div4not2),
    .phase        (phase),
    .rise_stb     (rise_stb),
    .fall_stb     (fall_stb),
    .busy         (busy)
`ifdef CLKSEQ_CHANGE_COUNT_EN
    ,
    .change_count (change_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 8 && phase !== p; i++) step();
    if (phase !== p) begin
      total_cnt++;
      $display("FAIL wait_phase: got %0d want %0d", phase, p);
    end
  endtask

  // exp_lat == 0 means only require that done_stb arrives within the bound.
  task automatic do_request(input logic val, input int exp_lat, input string name);
    int lat;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    req_valid = 1'b1;
    req_div4not2 = val;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (done_stb !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    total_cnt++;
    if (exp_lat == 0) begin
      if (done_stb !== 1'b1) $display("FAIL %s_done: no done_stb within %0d cycles", name, lat);
      else pass_cnt++;
    end else begin
      if (lat != exp_lat) $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
      else pass_cnt++;
    end
    total_cnt++;
    if (div4not2 !== val) $display("FAIL %s_div4not2: got %b want %b", name, div4not2, val);
    else pass_cnt++;
    step();
    total_cnt++;
    if (done_stb !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL %s_after_done: done_stb=%b req_ready=%b want 0/1", name, done_stb, req_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    step();
    step();
    total_cnt++;
    if ({div4not2, phase, req_ready, done_stb, rise_stb, fall_stb, busy} !== 8'b1_00_1_0_0_0_0)
      $display("FAIL reset_values: div4=%b phase=%0d ready=%b done=%b rise=%b fall=%b busy=%b want 1/0/1/0/0/0/0",
               div4not2, phase, req_ready, done_stb, rise_stb, fall_stb, busy);
    else pass_cnt++;
    resetb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (phase !== 2'(i % 4)) $display("FAIL run_phase: got %0d want %0d", phase, i % 4);
      else pass_cnt++;
      total_cnt++;
      if (rise_stb !== (i % 4 == 3)) $display("FAIL run_rise: got %b at step %0d", rise_stb, i);
      else pass_cnt++;
      total_cnt++;
      if (fall_stb !== (i % 4 == 1)) $display("FAIL run_fall: got %b at step %0d", fall_stb, i);
      else pass_cnt++;
      total_cnt++;
      if (req_ready !== 1'b1) $display("FAIL run_ready: got %b want 1", req_ready);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_same_mode();
    do_request(1'b1, 1, "same_mode");
`ifdef CLKSEQ_CHANGE_COUNT_EN
    total_cnt++;
    if (change_count !== 8'd0) $display("FAIL same_mode_count: got %0d want 0", change_count);
    else pass_cnt++;
`endif
  endtask

  // /4 -> /2 accepted at phase 1: wrap two cycles later, two settle cycles, then done.
  task automatic test_switch_div2();
    logic [1:0] ph_t [6];
    logic       d4_t [6];
    logic       dn_t [6];
    logic       bz_t [6];
    ph_t = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1};
    d4_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    dn_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bz_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    wait_phase(2'd1);
    req_valid = 1'b1;
    req_div4not2 = 1'b0;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      total_cnt++;
      if ({phase, div4not2, done_stb, busy} !== {ph_t[k], d4_t[k], dn_t[k], bz_t[k]})
        $display("FAIL switch_div2_k%0d: phase=%0d div4=%b done=%b busy=%b want %0d/%b/%b/%b",
                 k + 1, phase, div4not2, done_stb, busy, ph_t[k], d4_t[k], dn_t[k], bz_t[k]);
      else pass_cnt++;
      step();
    end
`ifdef CLKSEQ_CHANGE_COUNT_EN
    total_cnt++;
    if (change_count !== 8'd1) $display("FAIL switch_div2_count: got %0d want 1", change_count);
    else pass_cnt++;
`endif
  endtask

  task automatic test_boundary_accept();
    wait_phase(2'd0);
    do_request(1'b1, 4, "to_div4_a");  // /2 accepted at phase 0: 1 + 2 + 1
    wait_phase(2'd3);
    req_valid = 1'b1;
    req_div4not2 = 1'b0;
    step();
    req_valid = 1'b0;
    total_cnt++;
    if (div4not2 !== 1'b1 || phase !== 2'd0)
      $display("FAIL bnd_accept_edge: div4=%b phase=%0d want 1/0", div4not2, phase);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) step();
    total_cnt++;
    if (div4not2 !== 1'b1 || phase !== 2'd3)
      $display("FAIL bnd_wait: div4=%b phase=%0d want 1/3", div4not2, phase);
    else pass_cnt++;
    step();
    total_cnt++;
    if (div4not2 !== 1'b0 || phase !== 2'd0)
      $display("FAIL bnd_switch: div4=%b phase=%0d want 0/0", div4not2, phase);
    else pass_cnt++;
    step();
    total_cnt++;
    if (done_stb !== 1'b0) $display("FAIL bnd_early_done: got %b want 0", done_stb);
    else pass_cnt++;
    step();
    total_cnt++;
    if (done_stb !== 1'b1) $display("FAIL bnd_done: got %b want 1", done_stb);
    else pass_cnt++;
    step();
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL bnd_ready: got %b want 1", req_ready);
    else pass_cnt++;
    wait_phase(2'd1);
    do_request(1'b1, 5, "to_div4_b");  // /2 accepted at phase 1: 2 + 2 + 1
`ifdef CLKSEQ_CHANGE_COUNT_EN
    total_cnt++;
    if (change_count !== 8'd4) $display("FAIL bnd_count: got %0d want 4", change_count);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    req_valid = 1'b1;
    req_div4not2 = 1'b0;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && div4not2 !== 1'b0; i++) step();
    total_cnt++;
    if (div4not2 !== 1'b0 || busy !== 1'b1)
      $display("FAIL abort_in_settle: div4=%b busy=%b want 0/1", div4not2, busy);
    else pass_cnt++;
    resetb = 1'b0;
    #1;
    total_cnt++;
    if ({div4not2, phase, req_ready, done_stb, rise_stb, fall_stb, busy} !== 8'b1_00_1_0_0_0_0)
      $display("FAIL abort_values: div4=%b phase=%0d ready=%b done=%b rise=%b fall=%b busy=%b want 1/0/1/0/0/0/0",
               div4not2, phase, req_ready, done_stb, rise_stb, fall_stb, busy);
    else pass_cnt++;
`ifdef CLKSEQ_CHANGE_COUNT_EN
    total_cnt++;
    if (change_count !== 8'd0) $display("FAIL abort_count: got %0d want 0", change_count);
    else pass_cnt++;
`endif
    step();
    step();
    resetb = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done_stb === 1'b1) saw_done = 1'b1;
      step();
    end
    total_cnt++;
    if (saw_done !== 1'b0) $display("FAIL abort_no_done: got done_stb after reset");
    else pass_cnt++;
    wait_phase(2'd0);
    do_request(1'b0, 6, "post_reset");  // /4 accepted at phase 0: 3 + 2 + 1
  endtask

  task automatic test_back_to_back();
    logic cur;
    cur = 1'b0;
    for (int n = 0; n < 300; n++) begin
      cur = ~cur;
      do_request(cur, 0, "alt");
    end
`ifdef CLKSEQ_CHANGE_COUNT_EN
    // One switch since the aborting reset plus 300 more: 301 mod 256.
    total_cnt++;
    if (change_count !== 8'd45) $display("FAIL alt_count: got %0d want 45", change_count);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_same_mode();
    test_switch_div2();
    test_boundary_accept();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
